jt49_eg_ext: RTL



---
 rtl/jt49_eg_ext.sv | 86 ++++++++
 1 files changed

// File: rtl/jt49_eg_ext.sv
// AY/YM envelope generator with parametrised gain width, integrated period
// prescaler and shape-register restart; covers all 16 envelope shapes.
module jt49_eg_ext #(
    parameter int W  = 5,
    parameter int PW = 16
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          cen,
    input  logic          restart,
    input  logic [3:0]    ctrl,
    input  logic [PW-1:0] period,
    output logic [W-1:0]  gain,
    output logic          holding
);

    localparam logic [W-1:0] MAX = '1;

    // shape bit positions within ctrl
    localparam int CONT = 3;
    localparam int ATT  = 2;
    localparam int ALT  = 1;
    localparam int HOLD = 0;

    logic [3:0]    ctrl_reg;
    logic          dir_reg;
    logic          holding_reg;
    logic [PW-1:0] cnt_reg;
    logic [W-1:0]  gain_reg;

    logic [PW:0]   cnt_inc;
    logic [PW:0]   per_eff;
    logic          step;
    logic          at_end;

    // One extra bit on the compare so cnt+1 never wraps below the period.
    always_comb begin
        cnt_inc = {1'b0, cnt_reg} + (PW+1)'(1);
        per_eff = (period == '0) ? (PW+1)'(1) : {1'b0, period};
        step    = (cnt_inc >= per_eff);
        at_end  = dir_reg ? (gain_reg == MAX) : (gain_reg == '0);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ctrl_reg    <= 4'b0000;
            dir_reg     <= 1'b0;
            holding_reg <= 1'b0;
            cnt_reg     <= '0;
            gain_reg    <= MAX;
        end else if (restart) begin
            ctrl_reg    <= ctrl;
            cnt_reg     <= '0;
            holding_reg <= 1'b0;
            dir_reg     <= ctrl[ATT];
            gain_reg    <= ctrl[ATT] ? '0 : MAX;
        end else if (cen) begin
            if (step) begin
                cnt_reg <= '0;
                if (!holding_reg) begin
                    if (!at_end) begin
                        gain_reg <= dir_reg ? gain_reg + W'(1) : gain_reg - W'(1);
                    end else if (!ctrl_reg[CONT]) begin
                        gain_reg    <= '0;
                        holding_reg <= 1'b1;
                    end else if (ctrl_reg[HOLD]) begin
                        gain_reg    <= ctrl_reg[ALT] ? ~gain_reg : gain_reg;
                        holding_reg <= 1'b1;
                    end else if (ctrl_reg[ALT]) begin
                        // triangle: endpoint repeats once while direction flips
                        dir_reg <= ~dir_reg;
                    end else begin
                        // sawtooth never flips dir, so ATT still gives the direction
                        gain_reg <= ctrl_reg[ATT] ? '0 : MAX;
                    end
                end
            end else begin
                cnt_reg <= cnt_inc[PW-1:0];
            end
        end
    end

    assign gain    = gain_reg;
    assign holding = holding_reg;

endmodule
